// File: rtl/accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : accum_seq
// Purpose  : Issue-side sequencer for the accumulator. It tags each partial dot
//            product coming out of the DPE with an accumulator address, an
//            accumulate flag and a last flag, so the read-modify-write
//            accumulator builds one output row per address. It also withholds
//            ready so that an address is never re-issued before the write
//            from its previous issue has landed.
//
// Build option:
//   ACCUM_SEQ_HAZARD_EN  defined   -> issue-history register and RMW hazard
//                                     interlock are present.
//                        undefined -> no interlock; o_ready = (state == RUN).
//                                     Software must then configure
//                                     rows >= HAZ_GAP+1.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   i_start        in   one-cycle pulse: latch configuration, start a vector
//   i_rows_m1      in   rows per subset minus 1 (must be < DEPTH)
//   i_subsets_m1   in   subsets per input vector minus 1
//   i_valid        in   DPE partial sum valid
//   i_data         in   DPE partial sum
//   o_ready        out  a beat is accepted this cycle when i_valid is high
//   o_valid        out  beat to accumulator (registered, one cycle per beat)
//   o_data         out  partial sum to accumulator
//   o_addr         out  accumulator address
//   o_accum        out  1 = add to stored value, 0 = overwrite
//   o_last         out  final subset for this address
//   o_busy         out  vector in progress
//   o_done         out  one-cycle pulse when the vector completes
//
// Revision : 1.0  initial release
// ============================================================================
module accum_seq #(
    parameter int DATAW   = 32,
    parameter int DEPTH   = 512,
    parameter int ADDRW   = 9,
    parameter int SUBW    = 8,
    parameter int HAZ_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [ADDRW-1:0] i_rows_m1,
    input  logic [SUBW-1:0]  i_subsets_m1,
    input  logic             i_valid,
    input  logic [DATAW-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    output logic [ADDRW-1:0] o_addr,
    output logic             o_accum,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Largest legal rows-minus-one value; a larger request is clamped so the
    // row counter can never address beyond the accumulator.
    localparam logic [ADDRW-1:0] C_ROWS_M1_MAX = ADDRW'(DEPTH - 1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;

    logic [ADDRW-1:0] rows_m1_q;
    logic [SUBW-1:0]  subs_m1_q;
    logic [ADDRW-1:0] r_q;
    logic [ADDRW-1:0] r_d;
    logic [SUBW-1:0]  s_q;
    logic [SUBW-1:0]  s_d;

    logic             valid_q;
    logic [DATAW-1:0] data_q;
    logic [ADDRW-1:0] addr_q;
    logic             accum_q;
    logic             last_q;
    logic             done_q;

    logic             w_run;
    logic             w_ready;
    logic             w_busy;
    logic             w_accept;
    logic             w_row_wrap;
    logic             w_final;
    logic             w_haz_ok;

    // ------------------------------------------------------------------------
    // Hazard interlock
    //
    // hist records which of the last HAZ_GAP cycles issued a beat. Addresses
    // are issued in strict cyclic order, so the previous issue of the current
    // address is exactly rows beats back. If fewer than rows beats issued in
    // the last HAZ_GAP cycles, that previous issue is at least HAZ_GAP+1
    // cycles old and its write has landed. During the first subset every
    // address is written fresh, so there is nothing to wait for.
    // ------------------------------------------------------------------------
`ifdef ACCUM_SEQ_HAZARD_EN
    logic [HAZ_GAP-1:0] hist_q;
    logic [HAZ_GAP-1:0] hist_d;
    logic [HAZ_GAP:0]   w_hist_ext;
    logic [ADDRW:0]     w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < HAZ_GAP; i++) begin
            w_pop = w_pop + {{ADDRW{1'b0}}, hist_q[i]};
        end
    end

    // popcount < rows  <=>  popcount <= rows_m1
    assign w_haz_ok   = (s_q == '0) || (w_pop <= {1'b0, rows_m1_q});

    // Shift in this cycle's issue; the extended vector keeps the expression
    // valid for any HAZ_GAP >= 1.
    assign w_hist_ext = {hist_q, w_accept};
    assign hist_d     = w_hist_ext[HAZ_GAP-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign w_haz_ok = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_final) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    //
    // Ready is derived from registered state only, never from i_valid, so an
    // upstream that waits for ready before raising valid cannot form a loop.
    // ------------------------------------------------------------------------
    always_comb begin
        w_run   = (state_q == S_RUN);
        w_busy  = (state_q != S_IDLE);
        w_ready = w_run && w_haz_ok;
    end

    assign w_accept   = w_ready && i_valid;
    assign w_row_wrap = (r_q == rows_m1_q);
    assign w_final    = w_row_wrap && (s_q == subs_m1_q);

    // ------------------------------------------------------------------------
    // Row / subset counters
    // ------------------------------------------------------------------------
    always_comb begin
        r_d = r_q;
        s_d = s_q;
        if ((state_q == S_IDLE) && i_start) begin
            r_d = '0;
            s_d = '0;
        end else if (w_accept) begin
            if (w_row_wrap) begin
                r_d = '0;
                s_d = s_q + SUBW'(1);
            end else begin
                r_d = r_q + ADDRW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            s_q       <= '0;
            rows_m1_q <= '0;
            subs_m1_q <= '0;
        end else begin
            r_q <= r_d;
            s_q <= s_d;
            if ((state_q == S_IDLE) && i_start) begin
                rows_m1_q <= (i_rows_m1 > C_ROWS_M1_MAX) ? C_ROWS_M1_MAX : i_rows_m1;
                subs_m1_q <= i_subsets_m1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered beat to the accumulator. Tags are taken from the counters as
    // they stand when the beat is accepted; fields hold between beats and
    // are qualified by o_valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            accum_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= w_accept;
            done_q  <= (state_q == S_DONE);
            if (w_accept) begin
                data_q  <= i_data;
                addr_q  <= r_q;
                accum_q <= (s_q != '0);
                last_q  <= (s_q == subs_m1_q);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign o_ready = w_ready;
    assign o_busy  = w_busy;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_addr  = addr_q;
    assign o_accum = accum_q;
    assign o_last  = last_q;
    assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_seq
// Purpose  : Self-checking bench for accum_seq. A reference model built from
//            beat indices (address = k mod rows, subset = k div rows) and the
//            per-address issue-spacing rule predicts every output cycle by
//            cycle, with random data and random valid patterns.
// Revision : 1.0  initial release
// ============================================================================
module tb_accum_seq;

    localparam int DATAW   = 32;
    localparam int DEPTH   = 512;
    localparam int ADDRW   = 9;
    localparam int SUBW    = 8;
    localparam int HAZ_GAP = 4;
`ifdef ACCUM_SEQ_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [ADDRW-1:0] i_rows_m1;
    logic [SUBW-1:0]  i_subsets_m1;
    logic             i_valid;
    logic [DATAW-1:0] i_data;
    logic             o_ready;
    logic             o_valid;
    logic [DATAW-1:0] o_data;
    logic [ADDRW-1:0] o_addr;
    logic             o_accum;
    logic             o_last;
    logic             o_busy;
    logic             o_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    accum_seq #(
        .DATAW   (DATAW),
        .DEPTH   (DEPTH),
        .ADDRW   (ADDRW),
        .SUBW    (SUBW),
        .HAZ_GAP (HAZ_GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_rows_m1    (i_rows_m1),
        .i_subsets_m1 (i_subsets_m1),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_addr       (o_addr),
        .o_accum      (o_accum),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_data"},  64'(o_data),  64'd0);
        check({tag, "_addr"},  64'(o_addr),  64'd0);
        check({tag, "_accum"}, 64'(o_accum), 64'd0);
        check({tag, "_last"},  64'(o_last),  64'd0);
        check({tag, "_busy"},  64'(o_busy),  64'd0);
        check({tag, "_done"},  64'(o_done),  64'd0);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
    endtask

    // One vector. vmode: 0 = valid held high, 1 = valid on even cycles,
    // 2 = random valid. mid_start pulses i_start during the run. rst_beat > 0
    // asserts reset just after that beat (1-based) appears on o_valid.
    task automatic run_vec(input int rm1, input int sm1, input int vmode,
                           input bit mid_start, input int rst_beat);
        int               rows;
        int               subs;
        int               n;
        int               acc_t[$];
        logic [DATAW-1:0] dq[$];
        int               k;
        int               fin;
        int               t;
        int               limit;
        int               sidx;
        bit               acc_prev;
        bit               exp_rdy;
        bit               v;

        rows     = rm1 + 1;
        subs     = sm1 + 1;
        n        = rows * subs;
        k        = 0;
        fin      = -1;
        t        = 0;
        acc_prev = 1'b0;
        limit    = n * (HAZ_GAP + 3) + 20;

        // Idle gap lets any issue history from a previous vector drain.
        i_valid = 1'b0;
        i_start = 1'b0;
        repeat (HAZ_GAP + 2) tick();

        i_rows_m1    = rm1[ADDRW-1:0];
        i_subsets_m1 = sm1[SUBW-1:0];
        i_start      = 1'b1;
        check("idle_busy",  64'(o_busy),  64'd0);
        check("idle_ready", 64'(o_ready), 64'd0);
        tick();
        i_start = 1'b0;

        forever begin
            if (acc_prev) begin
                sidx = (k - 1) / rows;
                check("valid", 64'(o_valid), 64'd1);
                check("addr",  64'(o_addr),  64'((k - 1) % rows));
                check("accum", 64'(o_accum), 64'(sidx != 0));
                check("last",  64'(o_last),  64'(sidx == subs - 1));
                check("data",  64'(o_data),  64'(dq[k - 1]));
                if (rst_beat > 0 && k == rst_beat) begin
                    #1 rst = 1'b1;
                    #1 check_all_zero("async_rst");
                    tick();
                    rst = 1'b0;
                    repeat (6) begin
                        tick();
                        check("post_rst_done",  64'(o_done),  64'd0);
                        check("post_rst_valid", 64'(o_valid), 64'd0);
                    end
                    return;
                end
            end else begin
                check("valid", 64'(o_valid), 64'd0);
            end

            check("done", 64'(o_done), 64'(fin >= 0 && t == fin + 2));
            check("busy", 64'(o_busy), 64'(fin < 0 || t <= fin + 1));

            // An address may re-issue only HAZ_GAP+1 cycles after its
            // previous issue, which was exactly rows beats earlier.
            exp_rdy = (k < n);
            if (exp_rdy && HAZ && k >= rows) begin
                exp_rdy = (t - acc_t[k - rows]) >= (HAZ_GAP + 1);
            end
            check("ready", 64'(o_ready), 64'(exp_rdy));

            if (fin >= 0 && t == fin + 2) break;
            if (t > limit) begin
                check("timeout", 64'(t), 64'(limit));
                break;
            end

            case (vmode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            i_valid  = v;
            i_data   = $urandom;
            i_start  = mid_start && (t == 10);
            acc_prev = v && exp_rdy;
            if (acc_prev) begin
                acc_t.push_back(t);
                dq.push_back(i_data);
                if (k == n - 1) fin = t;
                k++;
            end
            tick();
            t++;
        end

        i_valid = 1'b0;
        i_start = 1'b0;
        if (fin >= 0) begin
            tick();
            check("done_pulse", 64'(o_done), 64'd0);
            check("count", 64'(k), 64'(n));
        end
    endtask

    initial begin
        rst          = 1'b1;
        i_start      = 1'b0;
        i_rows_m1    = '0;
        i_subsets_m1 = '0;
        i_valid      = 1'b0;
        i_data       = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        run_vec(7, 2, 0, 1'b0, 0);   // 24 contiguous beats
        run_vec(0, 3, 0, 1'b0, 0);   // single row, 5-cycle spacing
        run_vec(1, 1, 0, 1'b0, 0);   // beats at 0,1 then 5,6
        run_vec(3, 0, 1, 1'b0, 0);   // toggling valid, single subset
        run_vec(0, 0, 0, 1'b0, 0);   // single beat
        run_vec(7, 2, 0, 1'b1, 0);   // stray i_start mid-vector
        run_vec(7, 2, 0, 1'b0, 5);   // reset after beat 5
        run_vec(7, 2, 0, 1'b0, 0);   // fresh restart

        for (int i = 0; i < 5; i++) begin
            run_vec(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 2, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
